// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch constants, state encoding and FIFO entry layout for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned DEPTH       = 2;
    localparam int unsigned PC_STEP     = 2;
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1);

    localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(16'h0000);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned; bit 0 of any target is dropped.
    function automatic logic [PC_WIDTH-1:0] pc_align(input logic [PC_WIDTH-1:0] pc);
        return pc & ~PC_WIDTH'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO between the memory port and decode; flush dominates push/pop.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_d;

    // Qualified push/pop and next occupancy.
    always_comb begin
        do_push = push & ~flush & ~full;
        do_pop  = pop & ~flush & ~empty;
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= wdata;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, drives a single-outstanding req/ack port,
// buffers fetched words for decode and restarts on redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready
);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q;
    logic [PC_WIDTH-1:0] fetch_pc_d;
    logic [PC_WIDTH-1:0] addr_q;
    logic                req_q;

    logic                ack_c;
    logic                push_c;
    logic                pop_c;
    logic                flush_c;
    logic [CNT_W-1:0]    count_after_c;
    fetch_entry_t        wr_entry_c;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    fetch_entry_t        head;

    // Next state, fetch PC and FIFO control; redirect overrides everything.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        ack_c            = req_q & imem_ack;
        flush_c          = redirect_valid;
        pop_c            = ~fifo_empty & instr_ready & ~redirect_valid;
        push_c           = 1'b0;
        count_after_c    = fifo_count + CNT_W'(1) - CNT_W'(pop_c);
        wr_entry_c.pc    = fetch_pc_q;
        wr_entry_c.instr = imem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (redirect_valid || !fifo_full) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    state_d = ack_c ? ST_FETCH : ST_DISCARD;
                end else if (ack_c) begin
                    push_c     = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);
                    if (count_after_c >= CNT_W'(DEPTH)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (ack_c) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = pc_align(redirect_pc);
        end
    end

    // The request address is frozen while a request waits for its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= (state_d != ST_IDLE);
            if (!(req_q && !imem_ack)) begin
                addr_q <= fetch_pc_d;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .flush (flush_c),
        .wdata (wr_entry_c),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = ~fifo_empty;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;

endmodule
